word_serial_adder: RTL and testbench

Word-serial wide adder stage wrapped around the team's parameterised N-bit ripple full adder (`fa`). It accepts an arbitrarily long operand pair one N-bit word per transfer (least-significant word first) over a valid/ready handshake, and chains the carry between words through a register. Each registered sum word goes downstream over a second valid/ready handshake, so one `fa` instance can add operands wider than N.

---
 rtl/word_serial_adder.sv | 162 ++++++++++++++++
 tb/tb_word_serial_adder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_serial_adder.sv
// word_serial_adder: word-serial wide adder built around an N-bit ripple adder.
// Operands arrive LSW first, one word pair per transfer. The carry between words
// is kept in c_q, and each sum word leaves through a registered valid/ready port.

// One-bit full adder cell, replicated once per bit inside fa.
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// Parameterised N-bit ripple-carry adder.
module fa #(
  parameter int N = 5
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);
  logic [N:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < N; i++) begin : g_bit
    fa_cell u_cell (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (c[i]),
      .s_o (sum_o[i]),
      .c_o (c[i+1])
    );
  end

  assign cout_o = c[N];
endmodule

module word_serial_adder #(
  parameter int N    = 5,
  parameter int IDXW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_a,
  input  logic [N-1:0]    in_b,
  input  logic            in_cin,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_sum,
  output logic            out_last,
  output logic            out_carry,
  output logic [IDXW-1:0] out_idx
);
  // FIRST uses the external carry-in; MID chains the carry of the previous word.
  localparam logic ST_FIRST = 1'b0;
  localparam logic ST_MID   = 1'b1;

  logic            state_q, state_d;
  logic            c_q, c_d;
  logic [IDXW-1:0] idx_q, idx_d;

  logic            ovld_q, ovld_d;
  logic [N-1:0]    osum_q, osum_d;
  logic            olast_q, olast_d;
  logic            ocarry_q, ocarry_d;
  logic [IDXW-1:0] oidx_q, oidx_d;

  logic            in_xfer, out_xfer;
  logic            fa_cin, fa_cout;
  logic [N-1:0]    fa_sum;

  // No skid buffer: a new word is accepted only if the output slot is free
  // or is being drained in this same cycle.
  assign in_ready = !ovld_q || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = ovld_q && out_ready;

  // A FIRST-state word never looks at c_q, so a previous operand cannot leak in.
  assign fa_cin = (state_q == ST_MID) ? c_q : in_cin;

  fa #(.N(N)) u_fa (
    .a_i    (in_a),
    .b_i    (in_b),
    .cin_i  (fa_cin),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

  // Next-state for the carry chain, state and saturating word index.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    idx_d   = idx_q;
    if (in_xfer) begin
      if (in_last) begin
        state_d = ST_FIRST;
        c_d     = 1'b0;
        idx_d   = '0;
      end else begin
        state_d = ST_MID;
        c_d     = fa_cout;
        idx_d   = (idx_q == {IDXW{1'b1}}) ? idx_q : idx_q + 1'b1;
      end
    end
  end

  // Next-state for the output register slot; data holds unless a word is loaded.
  always_comb begin
    ovld_d   = ovld_q;
    osum_d   = osum_q;
    olast_d  = olast_q;
    ocarry_d = ocarry_q;
    oidx_d   = oidx_q;
    if (in_xfer) begin
      ovld_d   = 1'b1;
      osum_d   = fa_sum;
      olast_d  = in_last;
      ocarry_d = in_last & fa_cout;
      oidx_d   = idx_q;
    end else if (out_xfer) begin
      ovld_d   = 1'b0;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FIRST;
      c_q      <= 1'b0;
      idx_q    <= '0;
      ovld_q   <= 1'b0;
      osum_q   <= '0;
      olast_q  <= 1'b0;
      ocarry_q <= 1'b0;
      oidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      idx_q    <= idx_d;
      ovld_q   <= ovld_d;
      osum_q   <= osum_d;
      olast_q  <= olast_d;
      ocarry_q <= ocarry_d;
      oidx_q   <= oidx_d;
    end
  end

  assign out_valid = ovld_q;
  assign out_sum   = osum_q;
  assign out_last  = olast_q;
  assign out_carry = ocarry_q;
  assign out_idx   = oidx_q;
endmodule

// File: tb/tb_word_serial_adder.sv
// Bench for word_serial_adder: two instances (IDXW=8 and IDXW=2) share stimulus.
// Expected words come from a wide-integer model of each operand and are queued;
// a monitor pops and compares on every output transfer.
module tb_word_serial_adder;
  localparam int N = 5;

  typedef struct packed {
    logic [N-1:0] sum;
    logic         last;
    logic         carry;
    logic [7:0]   idx8;
    logic [1:0]   idx2;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_cin, in_last, out_ready;
  logic [N-1:0] in_a, in_b;
  logic         in_ready, out_valid, out_last, out_carry;
  logic [N-1:0] out_sum;
  logic [7:0]   out_idx;
  logic         in_ready2, out_valid2, out_last2, out_carry2;
  logic [N-1:0] out_sum2;
  logic [1:0]   out_idx2;

  exp_t         sbq[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           rdy_mode = 0;   // 0: ready high, 1: ready low, 2: random
  logic [N-1:0] opa[0:31];
  logic [N-1:0] opb[0:31];

  always #5 clk = ~clk;

  word_serial_adder #(.N(N), .IDXW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_last(out_last), .out_carry(out_carry), .out_idx(out_idx)
  );

  word_serial_adder #(.N(N), .IDXW(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2),
    .out_last(out_last2), .out_carry(out_carry2), .out_idx(out_idx2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Whole-operand reference: add the operands as wide integers, then slice words.
  task automatic model_push(input int len, input logic cin);
    logic [127:0] A, B, S;
    exp_t e;
    A = '0;
    B = '0;
    for (int k = 0; k < len; k++) begin
      A = A | (128'(opa[k]) << (N * k));
      B = B | (128'(opb[k]) << (N * k));
    end
    S = A + B + 128'(cin);
    for (int k = 0; k < len; k++) begin
      e.sum   = S[N*k +: N];
      e.last  = (k == len - 1);
      e.carry = e.last ? S[N*len] : 1'b0;
      e.idx8  = (k > 255) ? 8'd255 : 8'(k);
      e.idx2  = (k > 3) ? 2'd3 : 2'(k);
      sbq.push_back(e);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_word(input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic cin, input logic last);
    int t;
    in_a = a; in_b = b; in_cin = cin; in_last = last; in_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL in_ready_timeout got=0 want=1");
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = N'($urandom); in_b = N'($urandom);
    in_cin = 1'($urandom); in_last = 1'($urandom);
  endtask

  task automatic send_op(input int len, input logic cin, input bit gaps);
    model_push(len, cin);
    for (int k = 0; k < len; k++) begin
      // carry-in on later words is garbage and must be ignored
      send_word(opa[k], opb[k], (k == 0) ? cin : 1'($urandom), k == len - 1);
      if (gaps && ($urandom_range(2) == 0)) begin
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sbq.size() != 0 || out_valid) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 500) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout got=%0d want=0", sbq.size());
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_sum"},   out_sum, 0);
    chk({tag, "_last"},  out_last, 0);
    chk({tag, "_carry"}, out_carry, 0);
    chk({tag, "_idx"},   out_idx, 0);
    chk({tag, "_ready"}, in_ready, 1);
    chk({tag, "_valid2"}, out_valid2, 0);
    chk({tag, "_idx2"},  out_idx2, 0);
  endtask

  // Downstream ready driver.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(3) != 0);
      endcase
    end
  end

  // Monitor: each output transfer must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_word got sum=%b idx=%0d want=none", out_sum, out_idx);
        end else begin
          e = sbq.pop_front();
          if ({out_sum, out_last, out_carry, out_idx, out_idx2} !== e ||
              {out_valid2, out_sum2, out_last2, out_carry2} !== {1'b1, e.sum, e.last, e.carry} ||
              in_ready2 !== in_ready) begin
            n_bad++;
            $display("FAIL out_word got sum=%b last=%b carry=%b idx=%0d idx2=%0d sum2=%b v2=%b want sum=%b last=%b carry=%b idx=%0d idx2=%0d",
                     out_sum, out_last, out_carry, out_idx, out_idx2, out_sum2, out_valid2,
                     e.sum, e.last, e.carry, e.idx8, e.idx2);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_last = 1'b0;
    #1;
    chk_zero("reset");
    #13 rst = 1'b0;
    @(posedge clk); #1;

    // single word
    opa[0] = 5'b10100; opb[0] = 5'b10010;
    send_op(1, 1'b0, 0);
    wait_drain();

    // carry chain
    opa[0] = 5'b11111; opb[0] = 5'b00001; opa[1] = 5'b00000; opb[1] = 5'b00000;
    send_op(2, 1'b0, 0);
    wait_drain();

    // backpressure on the same chain
    rdy_mode = 1;
    repeat (2) @(posedge clk); #1;
    model_push(2, 1'b0);
    send_word(5'b11111, 5'b00001, 1'b0, 1'b0);
    in_a = '0; in_b = '0; in_cin = 1'b0; in_last = 1'b1; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", out_sum, 0);
      chk("bp_idx", out_idx, 0);
    end
    rdy_mode = 0;
    send_word(5'b00000, 5'b00000, 1'b0, 1'b1);
    wait_drain();

    // back-to-back single-word operands
    opa[0] = 5'b11001; opb[0] = 5'b10001;
    send_op(1, 1'b1, 0);
    opa[0] = 5'b01100; opb[0] = 5'b00110;
    send_op(1, 1'b1, 0);
    wait_drain();

    // asynchronous reset in the middle of an operand
    rdy_mode = 1;
    repeat (2) @(posedge clk); #1;
    send_word(5'b11111, 5'b00001, 1'b0, 1'b0);
    chk("rst_pre_valid", out_valid, 1);
    #3 rst = 1'b1;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    chk_zero("rst_held");
    rdy_mode = 0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    opa[0] = 5'b00001; opb[0] = 5'b00001;
    send_op(1, 1'b0, 0);
    wait_drain();

    // index saturation (visible on the IDXW=2 instance), then restart at 0
    for (int k = 0; k < 7; k++) begin
      opa[k] = N'($urandom); opb[k] = N'($urandom);
    end
    send_op(7, 1'($urandom), 0);
    opa[0] = N'($urandom); opb[0] = N'($urandom);
    opa[1] = N'($urandom); opb[1] = N'($urandom);
    send_op(2, 1'($urandom), 0);
    wait_drain();

    // randomized operands with gaps and random backpressure
    rdy_mode = 2;
    repeat (40) begin
      int len;
      len = $urandom_range(12, 1);
      for (int k = 0; k < len; k++) begin
        opa[k] = N'($urandom); opb[k] = N'($urandom);
      end
      send_op(len, 1'($urandom), 1);
    end
    rdy_mode = 0;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
